renode_mem_arbiter: RTL and testbench

Round-robin arbiter that shares the single Renode-backed memory port between `NumPorts` bus controllers in the testbench top. It accepts simple request/grant transactions from each requester, serialises them onto one downstream port with exactly one transaction outstanding, and routes each response back to its owner. A per-transaction timeout turns a missing response into an error response, so a hung co-simulation cannot deadlock the bench.

---
 rtl/renode_mem_arbiter_pkg.sv | 33 +++
 rtl/renode_mem_arbiter_if.sv | 44 ++++
 rtl/rr_arbiter.sv | 32 +++
 rtl/renode_mem_arbiter.sv | 126 ++++++++++++
 tb/tb_renode_mem_arbiter.sv | 457 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/renode_mem_arbiter_pkg.sv
// Shared types and defaults for the Renode memory-port arbiter.
package renode_mem_arbiter_pkg;

   localparam int unsigned NumPortsDef      = 4;
   localparam int unsigned AddrWidthDef     = 32;
   localparam int unsigned DataWidthDef     = 64;
   localparam int unsigned BeWidthDef       = DataWidthDef / 8;
   localparam int unsigned TimeoutCyclesDef = 256;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2
   } arb_state_e;

   typedef struct packed {
      logic                    we;
      logic [AddrWidthDef-1:0] addr;
      logic [DataWidthDef-1:0] wdata;
      logic [BeWidthDef-1:0]   be;
   } mem_req_t;

   typedef struct packed {
      logic [DataWidthDef-1:0] rdata;
      logic                    err;
   } mem_rsp_t;

   // Round-robin successor of idx, wrapping at n-1 -> 0 (n need not be a power of two).
   function automatic int unsigned rr_wrap_inc(input int unsigned idx, input int unsigned n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/renode_mem_arbiter_if.sv
// Upstream request/response bundle and downstream memory port of the arbiter.
interface renode_mem_arbiter_if #(
   parameter int unsigned NumPorts  = 4,
   parameter int unsigned AddrWidth = 32,
   parameter int unsigned DataWidth = 64
);
   localparam int unsigned BeWidth = DataWidth / 8;

   logic [NumPorts-1:0]           in_req_i;
   logic [NumPorts-1:0]           in_we_i;
   logic [NumPorts*AddrWidth-1:0] in_addr_i;
   logic [NumPorts*DataWidth-1:0] in_wdata_i;
   logic [NumPorts*BeWidth-1:0]   in_be_i;
   logic [NumPorts-1:0]           in_gnt_o;
   logic [NumPorts-1:0]           in_rvalid_o;
   logic [DataWidth-1:0]          in_rdata_o;
   logic                          in_err_o;

   logic                          mem_req_o;
   logic                          mem_we_o;
   logic [AddrWidth-1:0]          mem_addr_o;
   logic [DataWidth-1:0]          mem_wdata_o;
   logic [BeWidth-1:0]            mem_be_o;
   logic                          mem_gnt_i;
   logic                          mem_rvalid_i;
   logic [DataWidth-1:0]          mem_rdata_i;
   logic                          mem_err_i;

   // Arbiter side.
   modport slave (
      input  in_req_i, in_we_i, in_addr_i, in_wdata_i, in_be_i,
      output in_gnt_o, in_rvalid_o, in_rdata_o, in_err_o,
      output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o,
      input  mem_gnt_i, mem_rvalid_i, mem_rdata_i, mem_err_i
   );

   // Environment side: requesters plus downstream memory.
   modport master (
      output in_req_i, in_we_i, in_addr_i, in_wdata_i, in_be_i,
      input  in_gnt_o, in_rvalid_o, in_rdata_o, in_err_o,
      input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o,
      output mem_gnt_i, mem_rvalid_i, mem_rdata_i, mem_err_i
   );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr_i wins.
module rr_arbiter #(
   parameter int unsigned NumPorts = 4
) (
   input  logic [NumPorts-1:0]         req_i,
   input  logic [$clog2(NumPorts)-1:0] ptr_i,
   output logic [NumPorts-1:0]         gnt_o,
   output logic [$clog2(NumPorts)-1:0] idx_o,
   output logic                        valid_o
);
   localparam int unsigned IdxW = $clog2(NumPorts);

   int unsigned cand;

   // Scan requesters starting at the pointer, wrapping at NumPorts.
   always_comb begin
      gnt_o   = '0;
      idx_o   = '0;
      valid_o = 1'b0;
      cand    = 0;
      for (int unsigned i = 0; i < NumPorts; i++) begin
         cand = 32'(ptr_i) + i;
         if (cand >= NumPorts) cand = cand - NumPorts;
         if (!valid_o && req_i[cand[IdxW-1:0]]) begin
            valid_o                 = 1'b1;
            gnt_o[cand[IdxW-1:0]]   = 1'b1;
            idx_o                   = cand[IdxW-1:0];
         end
      end
   end

endmodule

// File: rtl/renode_mem_arbiter.sv
// Serialises NumPorts requesters onto one memory port, one transaction in
// flight, with a response timeout that converts a hang into an error.
module renode_mem_arbiter
   import renode_mem_arbiter_pkg::*;
#(
   parameter int unsigned NumPorts      = NumPortsDef,
   parameter int unsigned AddrWidth     = AddrWidthDef,
   parameter int unsigned DataWidth     = DataWidthDef,
   parameter int unsigned TimeoutCycles = TimeoutCyclesDef
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   renode_mem_arbiter_if.slave  bus,
   output logic                 busy_o
);
   localparam int unsigned IdxW    = $clog2(NumPorts);
   localparam int unsigned CntW    = $clog2(TimeoutCycles);
   localparam int unsigned BeWidth = DataWidth / 8;

   arb_state_e           state_q, state_d;
   logic [IdxW-1:0]      rr_q, rr_d;
   logic [IdxW-1:0]      owner_q, owner_d;
   logic [CntW-1:0]      cnt_q, cnt_d;
   mem_req_t             req_q, req_d;

   logic [NumPorts-1:0]  arb_gnt;
   logic [IdxW-1:0]      arb_idx;
   logic                 arb_valid;

   logic [NumPorts-1:0]  gnt;
   logic [NumPorts-1:0]  rvalid;
   mem_rsp_t             rsp;
   logic                 mem_req;

   rr_arbiter #(
      .NumPorts (NumPorts)
   ) u_rr (
      .req_i   (bus.in_req_i),
      .ptr_i   (rr_q),
      .gnt_o   (arb_gnt),
      .idx_o   (arb_idx),
      .valid_o (arb_valid)
   );

   // State, pointer, owner, timeout counter and captured request.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         rr_q    <= '0;
         owner_q <= '0;
         cnt_q   <= '0;
         req_q   <= '0;
      end else begin
         state_q <= state_d;
         rr_q    <= rr_d;
         owner_q <= owner_d;
         cnt_q   <= cnt_d;
         req_q   <= req_d;
      end
   end

   // Next-state and combinational grant/response routing.
   always_comb begin
      state_d = state_q;
      rr_d    = rr_q;
      owner_d = owner_q;
      cnt_d   = cnt_q;
      req_d   = req_q;
      gnt     = '0;
      rvalid  = '0;
      rsp     = '0;
      mem_req = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (arb_valid) begin
               gnt     = arb_gnt;
               owner_d = arb_idx;
               rr_d    = IdxW'(rr_wrap_inc(32'(arb_idx), NumPorts));
               for (int unsigned p = 0; p < NumPorts; p++) begin
                  if (arb_idx == IdxW'(p)) begin
                     req_d.we    = bus.in_we_i[p];
                     req_d.addr  = bus.in_addr_i[p*AddrWidth +: AddrWidth];
                     req_d.wdata = bus.in_wdata_i[p*DataWidth +: DataWidth];
                     req_d.be    = bus.in_be_i[p*BeWidth +: BeWidth];
                  end
               end
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            mem_req = 1'b1;
            if (bus.mem_gnt_i) begin
               cnt_d   = '0;
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (bus.mem_rvalid_i) begin
               rvalid[owner_q] = 1'b1;
               rsp.rdata       = req_q.we ? '0 : bus.mem_rdata_i;
               rsp.err         = bus.mem_err_i;
               state_d         = IDLE;
            end else if (cnt_q == CntW'(TimeoutCycles - 1)) begin
               rvalid[owner_q] = 1'b1;
               rsp.err         = 1'b1;
               state_d         = IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.in_gnt_o    = gnt;
   assign bus.in_rvalid_o = rvalid;
   assign bus.in_rdata_o  = rsp.rdata;
   assign bus.in_err_o    = rsp.err;
   assign bus.mem_req_o   = mem_req;
   assign bus.mem_we_o    = req_q.we;
   assign bus.mem_addr_o  = req_q.addr;
   assign bus.mem_wdata_o = req_q.wdata;
   assign bus.mem_be_o    = req_q.be;
   assign busy_o          = (state_q != IDLE);

endmodule

// File: tb/tb_renode_mem_arbiter.sv
// Scoreboard bench for renode_mem_arbiter with a behavioural downstream memory.
module tb_renode_mem_arbiter;

   localparam int NP = 4;
   localparam int AW = 32;
   localparam int DW = 64;
   localparam int BW = DW / 8;
   localparam int TO = 16;

   localparam int EXP_NONE = 0;
   localparam int EXP_OK   = 1;
   localparam int EXP_ERR  = 2;

   typedef struct {
      int          port;
      logic [63:0] data;
      logic        err;
   } exp_t;

   logic clk;
   logic rst_ni;
   logic busy;

   int checks   = 0;
   int failures = 0;

   exp_t        sb[$];
   logic [3:0]  gnt_log[$];
   logic [63:0] exp_mem[logic [31:0]];
   logic [63:0] resp_mem[logic [31:0]];

   int gnt_delay = 0;
   bit drop_rsp  = 0;
   int late_req  = 0;

   renode_mem_arbiter_if #(.NumPorts(NP), .AddrWidth(AW), .DataWidth(DW)) bus ();

   renode_mem_arbiter #(
      .NumPorts      (NP),
      .AddrWidth     (AW),
      .DataWidth     (DW),
      .TimeoutCycles (TO)
   ) dut (
      .clk_i  (clk),
      .rst_ni (rst_ni),
      .bus    (bus),
      .busy_o (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] wd,
                                         input logic [7:0] be);
      logic [63:0] r;
      r = old;
      for (int b = 0; b < 8; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
      return r;
   endfunction

   function automatic logic [63:0] exp_read(input logic [31:0] a);
      return exp_mem.exists(a) ? exp_mem[a] : {a, ~a};
   endfunction

   function automatic logic [63:0] resp_read(input logic [31:0] a);
      return resp_mem.exists(a) ? resp_mem[a] : {a, ~a};
   endfunction

   // Grant monitor.
   initial begin
      forever begin
         @(negedge clk);
         if (bus.in_gnt_o != '0) gnt_log.push_back(bus.in_gnt_o);
      end
   end

   // Downstream memory: grants after gnt_delay stall cycles, responds one cycle later.
   initial begin
      int          phase;
      int          gcnt;
      int          late_done;
      logic        lwe;
      logic [31:0] la;
      logic [63:0] lwd;
      logic [7:0]  lbe;
      phase = 0; gcnt = 0; late_done = 0;
      lwe = 0; la = '0; lwd = '0; lbe = '0;
      bus.mem_gnt_i = 0; bus.mem_rvalid_i = 0; bus.mem_rdata_i = '0; bus.mem_err_i = 0;
      forever begin
         @(posedge clk);
         #1;
         bus.mem_gnt_i    = 0;
         bus.mem_rvalid_i = 0;
         bus.mem_rdata_i  = '0;
         bus.mem_err_i    = 0;
         if (!rst_ni) begin
            phase = 0;
            continue;
         end
         if (late_req != late_done) begin
            late_done++;
            bus.mem_rvalid_i = 1;
            bus.mem_rdata_i  = 64'hBAD0_BAD0_BAD0_BAD0;
         end
         if (phase == 0 && bus.mem_req_o) begin
            gcnt  = gnt_delay;
            phase = 1;
         end
         if (phase == 1) begin
            if (gcnt == 0) begin
               bus.mem_gnt_i = 1;
               lwe = bus.mem_we_o; la = bus.mem_addr_o; lwd = bus.mem_wdata_o; lbe = bus.mem_be_o;
               phase = 2;
            end else begin
               gcnt--;
            end
         end else if (phase == 2) begin
            phase = 0;
            if (!drop_rsp) begin
               bus.mem_rvalid_i = 1;
               if (lwe) begin
                  resp_mem[la]    = merge(resp_read(la), lwd, lbe);
                  bus.mem_rdata_i = '1;
               end else begin
                  bus.mem_rdata_i = resp_read(la);
               end
            end
         end
      end
   end

   task automatic start_req(input int p, input logic we, input logic [31:0] addr,
                            input logic [63:0] wd, input logic [7:0] be, input int mode);
      exp_t e;
      if (mode == EXP_OK) begin
         e.port = p; e.err = 0;
         e.data = we ? 64'h0 : exp_read(addr);
         if (we) exp_mem[addr] = merge(exp_read(addr), wd, be);
         sb.push_back(e);
      end else if (mode == EXP_ERR) begin
         e.port = p; e.err = 1; e.data = 64'h0;
         sb.push_back(e);
      end
      bus.in_we_i[p]               = we;
      bus.in_addr_i[p*AW +: AW]    = addr;
      bus.in_wdata_i[p*DW +: DW]   = wd;
      bus.in_be_i[p*BW +: BW]      = be;
      bus.in_req_i[p]              = 1'b1;
   endtask

   task automatic finish_req(input int p);
      bit seen;
      seen = 0;
      for (int c = 0; c < 100 && !seen; c++) begin
         @(negedge clk);
         if (bus.in_gnt_o[p]) seen = 1;
      end
      checks++;
      if (!seen) begin
         failures++;
         $display("FAIL grant_timeout port=%0d got=0 exp=1", p);
      end
      @(posedge clk);
      #1;
      bus.in_req_i[p] = 1'b0;
   endtask

   task automatic issue(input int p, input logic we, input logic [31:0] addr,
                        input logic [63:0] wd, input logic [7:0] be, input int mode);
      @(posedge clk);
      #1;
      start_req(p, we, addr, wd, be, mode);
      finish_req(p);
   endtask

   task automatic collect(input int n);
      int   got;
      exp_t e;
      logic [3:0] eo;
      got = 0;
      for (int c = 0; c < 200 && got < n; c++) begin
         @(negedge clk);
         if (bus.in_rvalid_o != '0) begin
            got++;
            checks++;
            if (sb.size() == 0) begin
               failures++;
               $display("FAIL unexpected_rvalid got=%b exp=none", bus.in_rvalid_o);
            end else begin
               e  = sb.pop_front();
               eo = 4'b0001 << e.port;
               if (bus.in_rvalid_o !== eo) begin
                  failures++;
                  $display("FAIL rsp_owner got=%b exp=%b", bus.in_rvalid_o, eo);
               end
               checks++;
               if (bus.in_rdata_o !== e.data) begin
                  failures++;
                  $display("FAIL rsp_data port=%0d got=%h exp=%h", e.port, bus.in_rdata_o, e.data);
               end
               checks++;
               if (bus.in_err_o !== e.err) begin
                  failures++;
                  $display("FAIL rsp_err port=%0d got=%b exp=%b", e.port, bus.in_err_o, e.err);
               end
            end
         end
      end
      checks++;
      if (got < n) begin
         failures++;
         $display("FAIL rsp_timeout got=%0d exp=%0d", got, n);
      end
   endtask

   task automatic wait_mem_handshake();
      bit seen;
      seen = 0;
      for (int c = 0; c < 50 && !seen; c++) begin
         @(negedge clk);
         if (bus.mem_req_o && bus.mem_gnt_i) seen = 1;
      end
      checks++;
      if (!seen) begin
         failures++;
         $display("FAIL mem_handshake_timeout got=0 exp=1");
      end
   endtask

   task automatic test_reset();
      rst_ni = 1'b0;
      bus.in_req_i = '0; bus.in_we_i = '0; bus.in_addr_i = '0;
      bus.in_wdata_i = '0; bus.in_be_i = '0;
      repeat (3) @(negedge clk);
      checks++;
      if ({bus.in_gnt_o, bus.in_rvalid_o, bus.in_rdata_o, bus.in_err_o, bus.mem_req_o,
           bus.mem_we_o, bus.mem_addr_o, bus.mem_wdata_o, bus.mem_be_o, busy} !== '0) begin
         failures++;
         $display("FAIL reset_outputs got=%h exp=0",
                  {bus.in_gnt_o, bus.in_rvalid_o, bus.in_rdata_o, bus.in_err_o, bus.mem_req_o,
                   bus.mem_we_o, bus.mem_addr_o, bus.mem_wdata_o, bus.mem_be_o, busy});
      end
      rst_ni = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if ({busy, bus.mem_req_o, bus.in_gnt_o} !== '0) begin
         failures++;
         $display("FAIL idle_after_reset got=%b exp=0", {busy, bus.mem_req_o, bus.in_gnt_o});
      end
   endtask

   task automatic test_all_ports();
      exp_t e;
      logic [3:0] eg;
      gnt_log.delete();
      @(posedge clk);
      #1;
      for (int p = 0; p < NP; p++) begin
         bus.in_we_i[p]             = 1'b0;
         bus.in_addr_i[p*AW +: AW]  = 32'h2000 + 32'(p * 16);
         bus.in_wdata_i[p*DW +: DW] = '0;
         bus.in_be_i[p*BW +: BW]    = '0;
         bus.in_req_i[p]            = 1'b1;
      end
      for (int r = 0; r < 2; r++) begin
         for (int p = 0; p < NP; p++) begin
            e.port = p; e.err = 0; e.data = exp_read(32'h2000 + 32'(p * 16));
            sb.push_back(e);
         end
      end
      collect(8);
      @(posedge clk);
      #1;
      bus.in_req_i = '0;
      checks++;
      if (gnt_log.size() != 8) begin
         failures++;
         $display("FAIL rr_grant_count got=%0d exp=8", gnt_log.size());
      end
      for (int i = 0; i < gnt_log.size() && i < 8; i++) begin
         eg = 4'b0001 << (i % 4);
         checks++;
         if (gnt_log[i] !== eg) begin
            failures++;
            $display("FAIL rr_order idx=%0d got=%b exp=%b", i, gnt_log[i], eg);
         end
      end
   endtask

   task automatic test_single_read();
      gnt_log.delete();
      issue(2, 1'b0, 32'h1000, 64'h0, 8'h00, EXP_OK);
      collect(1);
      checks++;
      if (gnt_log.size() != 1 || gnt_log[0] !== 4'b0100) begin
         failures++;
         $display("FAIL single_grant got_n=%0d got=%b exp=0100",
                  gnt_log.size(), (gnt_log.size() > 0) ? gnt_log[0] : 4'b0);
      end
   endtask

   task automatic test_write_read();
      issue(1, 1'b1, 32'h1000, 64'h200, 8'hFF, EXP_OK);
      collect(1);
      issue(1, 1'b0, 32'h1000, 64'h0, 8'h00, EXP_OK);
      collect(1);
   endtask

   task automatic test_gnt_stall();
      logic [113:0] exp_bus;
      logic [113:0] got_bus;
      gnt_delay = 10;
      gnt_log.delete();
      issue(0, 1'b1, 32'h3000, 64'hA5A5_0000_1234_5678, 8'h3C, EXP_OK);
      start_req(1, 1'b0, 32'h3008, 64'h0, 8'h00, EXP_OK);
      exp_bus = {1'b1, 1'b1, 32'h3000, 64'hA5A5_0000_1234_5678, 8'h3C, 4'b0000, 1'b0, 1'b1};
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         got_bus = {bus.mem_req_o, bus.mem_we_o, bus.mem_addr_o, bus.mem_wdata_o, bus.mem_be_o,
                    bus.in_gnt_o, bus.mem_gnt_i, busy};
         checks++;
         if (got_bus !== exp_bus) begin
            failures++;
            $display("FAIL stall_stable cyc=%0d got=%h exp=%h", c, got_bus, exp_bus);
         end
      end
      gnt_delay = 0;
      fork
         finish_req(1);
         collect(2);
      join
      checks++;
      if (gnt_log.size() != 2) begin
         failures++;
         $display("FAIL stall_grant_count got=%0d exp=2", gnt_log.size());
      end
   endtask

   task automatic test_timeout();
      int   k;
      bit   seen;
      exp_t e;
      logic [3:0] eo;
      drop_rsp = 1;
      gnt_log.delete();
      issue(3, 1'b0, 32'h5000, 64'h0, 8'h00, EXP_ERR);
      wait_mem_handshake();
      k = 0; seen = 0;
      while (k < 40 && !seen) begin
         @(negedge clk);
         k++;
         if (bus.in_rvalid_o != '0) seen = 1;
      end
      checks++;
      if (!seen || k != TO) begin
         failures++;
         $display("FAIL timeout_latency got=%0d exp=%0d", seen ? k : -1, TO);
      end
      if (seen && sb.size() > 0) begin
         e  = sb.pop_front();
         eo = 4'b0001 << e.port;
         checks++;
         if ({bus.in_rvalid_o, bus.in_rdata_o, bus.in_err_o} !== {eo, e.data, e.err}) begin
            failures++;
            $display("FAIL timeout_rsp got=%b/%h/%b exp=%b/%h/%b", bus.in_rvalid_o,
                     bus.in_rdata_o, bus.in_err_o, eo, e.data, e.err);
         end
      end
      drop_rsp = 0;
      repeat (4) @(negedge clk);
      late_req++;
      @(negedge clk);
      checks++;
      if ({bus.in_rvalid_o, bus.in_err_o, busy} !== '0) begin
         failures++;
         $display("FAIL late_rvalid_ignored got=%b exp=0", {bus.in_rvalid_o, bus.in_err_o, busy});
      end
      issue(1, 1'b0, 32'h5008, 64'h0, 8'h00, EXP_OK);
      collect(1);
      checks++;
      if (gnt_log.size() != 2 || gnt_log[1] !== 4'b0010) begin
         failures++;
         $display("FAIL post_timeout_grant got_n=%0d exp_n=2", gnt_log.size());
      end
   endtask

   task automatic test_reset_in_wait();
      drop_rsp = 1;
      issue(2, 1'b1, 32'h4000, 64'h1111_2222_3333_4444, 8'h0F, EXP_NONE);
      wait_mem_handshake();
      @(negedge clk);
      checks++;
      if (busy !== 1'b1 || bus.mem_addr_o !== 32'h4000) begin
         failures++;
         $display("FAIL pre_reset_wait got=%b/%h exp=1/00004000", busy, bus.mem_addr_o);
      end
      rst_ni = 1'b0;
      #1;
      checks++;
      if ({bus.in_gnt_o, bus.in_rvalid_o, bus.in_rdata_o, bus.in_err_o, bus.mem_req_o,
           bus.mem_we_o, bus.mem_addr_o, bus.mem_wdata_o, bus.mem_be_o, busy} !== '0) begin
         failures++;
         $display("FAIL async_reset_outputs got=%h exp=0",
                  {bus.in_gnt_o, bus.in_rvalid_o, bus.in_rdata_o, bus.in_err_o, bus.mem_req_o,
                   bus.mem_we_o, bus.mem_addr_o, bus.mem_wdata_o, bus.mem_be_o, busy});
      end
      repeat (3) @(negedge clk);
      drop_rsp = 0;
      rst_ni   = 1'b1;
      gnt_log.delete();
      @(posedge clk);
      #1;
      start_req(0, 1'b0, 32'h6010, 64'h0, 8'h00, EXP_OK);
      start_req(3, 1'b0, 32'h6000, 64'h0, 8'h00, EXP_OK);
      fork
         begin
            finish_req(0);
            finish_req(3);
         end
         collect(2);
      join
      checks++;
      if (gnt_log.size() != 2 || gnt_log[0] !== 4'b0001 || gnt_log[1] !== 4'b1000) begin
         failures++;
         $display("FAIL post_reset_order got=%b,%b exp=0001,1000",
                  (gnt_log.size() > 0) ? gnt_log[0] : 4'b0,
                  (gnt_log.size() > 1) ? gnt_log[1] : 4'b0);
      end
   endtask

   initial begin
      exp_mem[32'h1000]  = 64'hDEAD_BEEF_0000_0200;
      resp_mem[32'h1000] = 64'hDEAD_BEEF_0000_0200;
      test_reset();
      test_all_ports();
      test_single_read();
      test_write_read();
      test_gnt_stall();
      test_timeout();
      test_reset_in_wait();
      repeat (3) @(negedge clk);
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_leftover got=%0d exp=0", sb.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=running exp=finished");
      $fatal(1, "simulation time limit");
   end

endmodule
